// File: rtl/traffic_light.sv
// ---------------------------------------------------------------------------
// traffic_light
//
// Purpose:
//   Controller for a main road / side road crossing with a pedestrian walk
//   phase that runs alongside the side-road green. Main road holds GREEN
//   until it has shown green for at least MIN_GREEN cycles and a side car
//   or pedestrian request is present. It then runs a fixed sequence:
//   yellow, all-red, side green, side yellow, all-red, and back to main
//   green.
//
// Parameters (each must be an integer in 1..255):
//   MIN_GREEN   - minimum cycles of main GREEN before yielding
//   SIDE_GREEN  - exact cycles of side GREEN
//   YELLOW_TIME - cycles in each yellow phase
//   ALLRED_TIME - cycles in each all-red clearance phase
//
// Ports:
//   clk        in   single clock; all state changes on the rising edge
//   reset      in   synchronous, active-high; overrides every other input
//   side_car   in   level side-road vehicle sensor (not latched)
//   ped_btn    in   pedestrian request; may be a single-cycle pulse
//   main_light out  2-bit light code for the main road
//   side_light out  2-bit light code for the side road
//   walk       out  pedestrian walk indicator (only during side green)
//   state      out  current FSM state, for debug
//
// Light code: RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2.
// ---------------------------------------------------------------------------
module traffic_light #(
    parameter int MIN_GREEN   = 8,
    parameter int SIDE_GREEN  = 6,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_car,
    input  logic       ped_btn,
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic       walk,
    output logic [2:0] state
);

    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;

    // Timer value seen in the last cycle of each phase. A phase of length N
    // spends timer values 0..N-1, so it leaves when the timer reads N-1.
    localparam logic [7:0] MIN_GREEN_LAST  = 8'(MIN_GREEN - 1);
    localparam logic [7:0] SIDE_GREEN_LAST = 8'(SIDE_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST     = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] ALLRED_LAST     = 8'(ALLRED_TIME - 1);
    localparam logic [7:0] TIMER_MAX       = 8'hFF;

    typedef enum logic [2:0] {
        MAIN_GO       = 3'd0,
        MAIN_SLOW     = 3'd1,
        CLEAR_TO_SIDE = 3'd2,
        SIDE_GO       = 3'd3,
        SIDE_SLOW     = 3'd4,
        CLEAR_TO_MAIN = 3'd5
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] timer_q;
    logic       ped_pending_q;
    logic       walk_q;
    logic       main_request;
    logic       entering_side;
    logic       leaving_side;

    assign main_request  = side_car | ped_pending_q | ped_btn;
    assign entering_side = (state_q == CLEAR_TO_SIDE) && (state_d == SIDE_GO);
    assign leaving_side  = (state_q == SIDE_GO) && (state_d != SIDE_GO);

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MAIN_GO:
                if ((timer_q >= MIN_GREEN_LAST) && main_request)
                    state_d = MAIN_SLOW;
            MAIN_SLOW:
                if (timer_q == YELLOW_LAST) state_d = CLEAR_TO_SIDE;
            CLEAR_TO_SIDE:
                if (timer_q == ALLRED_LAST) state_d = SIDE_GO;
            SIDE_GO:
                if (timer_q == SIDE_GREEN_LAST) state_d = SIDE_SLOW;
            SIDE_SLOW:
                if (timer_q == YELLOW_LAST) state_d = CLEAR_TO_MAIN;
            CLEAR_TO_MAIN:
                if (timer_q == ALLRED_LAST) state_d = MAIN_GO;
            // Encodings 6 and 7 recover to main green on the next edge.
            default:
                state_d = MAIN_GO;
        endcase
    end

    // Lights are a pure function of the state; unknown states show all-red.
    always_comb begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
        case (state_q)
            MAIN_GO:   main_light = LIGHT_GREEN;
            MAIN_SLOW: main_light = LIGHT_YELLOW;
            SIDE_GO:   side_light = LIGHT_GREEN;
            SIDE_SLOW: side_light = LIGHT_YELLOW;
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= MAIN_GO;
            timer_q       <= 8'd0;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q)
                timer_q <= 8'd0;
            else if (timer_q != TIMER_MAX)
                timer_q <= timer_q + 8'd1;

            // The request is consumed on entry to side green. Inside side
            // green the button is ignored, except on the edge that leaves
            // it, so that press is remembered for the next cycle.
            if (entering_side)
                ped_pending_q <= 1'b0;
            else if (ped_btn && ((state_q != SIDE_GO) || leaving_side))
                ped_pending_q <= 1'b1;

            // Walk is decided once at side-green entry and held for the
            // whole phase.
            if (entering_side)
                walk_q <= ped_pending_q | ped_btn;
            else if (leaving_side)
                walk_q <= 1'b0;
        end
    end

    assign walk  = walk_q;
    assign state = state_q;

endmodule

// File: tb/tb_traffic_light.sv
// ---------------------------------------------------------------------------
// tb_traffic_light
//
// Self-checking bench for traffic_light with default parameters. A
// phase-table reference model (phase index, cycles spent in phase, pending
// request, walk flag) predicts the lights, walk and state for every cycle.
// Directed scenarios additionally compare against fixed cycle tables.
// Cycle 0 is the first cycle with reset low.
// ---------------------------------------------------------------------------
module tb_traffic_light;

    localparam int MIN_GREEN   = 8;
    localparam int SIDE_GREEN  = 6;
    localparam int YELLOW_TIME = 3;
    localparam int ALLRED_TIME = 2;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       side_car;
    logic       ped_btn;
    logic [1:0] main_light;
    logic [1:0] side_light;
    logic       walk;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    int m_phase;
    int m_age;
    bit m_pend;
    bit m_walk;

    traffic_light #(
        .MIN_GREEN  (MIN_GREEN),
        .SIDE_GREEN (SIDE_GREEN),
        .YELLOW_TIME(YELLOW_TIME),
        .ALLRED_TIME(ALLRED_TIME)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .side_car  (side_car),
        .ped_btn   (ped_btn),
        .main_light(main_light),
        .side_light(side_light),
        .walk      (walk),
        .state     (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [1:0] main_of(input int p);
        if (p == 0) return GRN;
        if (p == 1) return YEL;
        return RED;
    endfunction

    function automatic logic [1:0] side_of(input int p);
        if (p == 3) return GRN;
        if (p == 4) return YEL;
        return RED;
    endfunction

    function automatic int len_of(input int p);
        case (p)
            1, 4:    return YELLOW_TIME;
            2, 5:    return ALLRED_TIME;
            3:       return SIDE_GREEN;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_vec();
        return {3'(m_phase), main_of(m_phase), side_of(m_phase), m_walk};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {state, main_light, side_light, walk};
    endfunction

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input logic sc, input logic pb, input logic rst);
        bit leave;
        if (rst) begin
            m_phase = 0;
            m_age   = 0;
            m_pend  = 0;
            m_walk  = 0;
            return;
        end
        if (m_phase == 0)
            leave = (m_age + 1 >= MIN_GREEN) && (sc || m_pend || pb);
        else
            leave = (m_age + 1 == len_of(m_phase));
        if (leave && m_phase == 2) begin
            m_walk = m_pend || pb;
            m_pend = 0;
        end else if (pb && !(m_phase == 3 && !leave)) begin
            m_pend = 1;
        end
        if (leave && m_phase == 3) m_walk = 0;
        m_age = leave ? 0 : m_age + 1;
        if (leave) m_phase = (m_phase + 1) % 6;
    endtask

    // Drive one cycle of inputs, advance the model, move to just after the
    // next rising edge.
    task automatic step(input logic sc, input logic pb, input logic rst);
        side_car = sc;
        ped_btn  = pb;
        reset    = rst;
        model_edge(sc, pb, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] exp;
        // Reset must win even with both requests high.
        step(1'b1, 1'b1, 1'b1);
        exp = {3'd0, GRN, RED, 1'b0};
        tests_run++;
        if (dut_vec() !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), exp);
        end
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL reset_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            tests_run++;
            if ({main_light, side_light, walk} !== {GRN, RED, 1'b0}) begin
                tests_failed++;
                $display("FAIL idle c=%0d: got %b expected %b", c,
                         {main_light, side_light, walk}, {GRN, RED, 1'b0});
            end
            step(1'b0, 1'b0, 1'b0);
        end
        // Timer is saturated by now; a request must yield after one edge.
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (state !== 3'd1) begin
            tests_failed++;
            $display("FAIL idle_saturated_exit: got %0d expected 1", state);
        end
        tests_run++;
        if (dut_vec() !== model_vec()) begin
            tests_failed++;
            $display("FAIL idle_model: got %h expected %h", dut_vec(), model_vec());
        end
    endtask

    function automatic logic [3:0] cont_table(input int c);
        if (c < 8)  return {GRN, RED};
        if (c < 11) return {YEL, RED};
        if (c < 13) return {RED, RED};
        if (c < 19) return {RED, GRN};
        if (c < 22) return {RED, YEL};
        if (c < 24) return {RED, RED};
        if (c < 32) return {GRN, RED};
        return {YEL, RED};
    endfunction

    task automatic test_continuous_side();
        do_reset();
        for (int c = 0; c < 35; c++) begin
            tests_run++;
            if ({main_light, side_light} !== cont_table(c)) begin
                tests_failed++;
                $display("FAIL cont_side c=%0d: got %b expected %b", c,
                         {main_light, side_light}, cont_table(c));
            end
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL cont_side_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    function automatic logic [4:0] ped_table(input int c);
        if (c <= 20) return {GRN, RED, 1'b0};
        if (c < 24)  return {YEL, RED, 1'b0};
        if (c < 26)  return {RED, RED, 1'b0};
        if (c < 32)  return {RED, GRN, 1'b1};
        if (c < 35)  return {RED, YEL, 1'b0};
        return {RED, RED, 1'b0};
    endfunction

    task automatic test_ped_pulse();
        do_reset();
        for (int c = 0; c < 36; c++) begin
            tests_run++;
            if ({main_light, side_light, walk} !== ped_table(c)) begin
                tests_failed++;
                $display("FAIL ped_pulse c=%0d: got %b expected %b", c,
                         {main_light, side_light, walk}, ped_table(c));
            end
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL ped_pulse_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            step(1'b0, 1'(c == 20), 1'b0);
        end
    endtask

    task automatic test_short_car();
        do_reset();
        for (int c = 0; c < 120; c++) begin
            tests_run++;
            if ({main_light, side_light} !== {GRN, RED}) begin
                tests_failed++;
                $display("FAIL short_car c=%0d: got %b expected %b", c,
                         {main_light, side_light}, {GRN, RED});
            end
            step(1'(c == 3 || c == 4), 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL rst_mid_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            // Button in SIDE_SLOW leaves a request pending at reset.
            step(1'b1, 1'(c == 19), 1'b0);
        end
        tests_run++;
        if (state !== 3'd4) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: got state %0d expected 4", state);
        end
        step(1'b1, 1'b1, 1'b1);
        tests_run++;
        if (dut_vec() !== {3'd0, GRN, RED, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_mid_after: got %h expected %h", dut_vec(),
                     {3'd0, GRN, RED, 1'b0});
        end
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (state !== 3'd0) begin
                tests_failed++;
                $display("FAIL rst_mid_no_serve c=%0d: got state %0d expected 0", c, state);
            end
        end
    endtask

    task automatic test_btn_during_walk();
        do_reset();
        for (int c = 0; c < 130; c++) begin
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL walk_btn_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            if (c == 15) begin
                tests_run++;
                if ({state, walk} !== {3'd3, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL walk_btn_in_walk: got %b expected %b",
                             {state, walk}, {3'd3, 1'b1});
                end
            end
            if (c >= 24) begin
                tests_run++;
                if (state !== 3'd0) begin
                    tests_failed++;
                    $display("FAIL walk_btn_hold c=%0d: got state %0d expected 0", c, state);
                end
            end
            step(1'b0, 1'(c == 0 || c == 15), 1'b0);
        end
    endtask

    task automatic test_btn_on_exit();
        do_reset();
        // c=18 is the last SIDE_GO cycle; that press must be remembered.
        for (int c = 0; c < 45; c++) begin
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL exit_btn_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            if (c == 31 || c == 32 || c == 37) begin
                tests_run++;
                if ({state, walk} !== ((c == 31) ? {3'd0, 1'b0} :
                                       (c == 32) ? {3'd1, 1'b0} : {3'd3, 1'b1})) begin
                    tests_failed++;
                    $display("FAIL exit_btn c=%0d: got state %0d walk %0d", c, state, walk);
                end
            end
            step(1'b0, 1'(c == 0 || c == 18), 1'b0);
        end
    endtask

    task automatic test_btn_on_entry();
        do_reset();
        // c=12 is the last CLEAR_TO_SIDE cycle with continuous side traffic.
        for (int c = 0; c < 41; c++) begin
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL entry_btn_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            if (c == 13 || c == 18 || c == 19 || c == 37) begin
                tests_run++;
                if (walk !== 1'(c == 13 || c == 18)) begin
                    tests_failed++;
                    $display("FAIL entry_btn c=%0d: got walk %0d expected %0d", c,
                             walk, (c == 13 || c == 18));
                end
            end
            step(1'b1, 1'(c == 12), 1'b0);
        end
    endtask

    task automatic test_random();
        logic sc;
        logic pb;
        logic rst;
        do_reset();
        sc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL random_model c=%0d: got %h expected %h", c,
                         dut_vec(), model_vec());
            end
            tests_run++;
            if (main_light !== RED && side_light !== RED) begin
                tests_failed++;
                $display("FAIL random_conflict c=%0d: got main %0d side %0d expected one RED",
                         c, main_light, side_light);
            end
            if ($urandom_range(7) == 0) sc = ~sc;
            pb  = 1'($urandom_range(19) == 0);
            rst = 1'($urandom_range(299) == 0);
            step(sc, pb, rst);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        side_car = 1'b0;
        ped_btn  = 1'b0;
        m_phase  = 0;
        m_age    = 0;
        m_pend   = 0;
        m_walk   = 0;
        test_reset();
        test_idle();
        test_continuous_side();
        test_ped_pulse();
        test_short_car();
        test_reset_mid_phase();
        test_btn_during_walk();
        test_btn_on_exit();
        test_btn_on_entry();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
